// File: rtl/sm_trace_pkg.sv
// sm_trace_pkg: shared state encoding and entry layout for the trace buffer.
// An entry is packed as {pc, instr, stamp} with the stamp in the low bits.
package sm_trace_pkg;
    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_HALTED  = 2'd2
    } tr_state_e;
    localparam int TR_STAMP_W = 16;
    localparam int TR_ENTRY_W = 64 + TR_STAMP_W;
    function automatic int tr_entry_w(int sw);
        return 64 + sw;
    endfunction
    function automatic int tr_instr_lsb(int sw);
        return sw;
    endfunction
    function automatic int tr_pc_lsb(int sw);
        return sw + 32;
    endfunction
endpackage

// File: rtl/sm_trace_buffer_if.sv
// sm_trace_buffer_if: control, fetch-stream and read-port signals of the trace buffer.
interface sm_trace_buffer_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STAMP_W    = 16
);
    logic                  start;
    logic                  clear;
    logic                  commit;
    logic [31:0]           pc;
    logic [31:0]           instr;
    logic                  rdReady;
    logic                  rdValid;
    logic [31:0]           rdPc;
    logic [31:0]           rdInstr;
    logic [STAMP_W-1:0]    rdStamp;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  halt;
    logic [1:0]            state;
    modport master (
        output start, clear, commit, pc, instr, rdReady,
        input  rdValid, rdPc, rdInstr, rdStamp, count, overflow, halt, state
    );
    modport slave (
        input  start, clear, commit, pc, instr, rdReady,
        output rdValid, rdPc, rdInstr, rdStamp, count, overflow, halt, state
    );
endinterface

// File: rtl/sm_trace_buffer_fifo.sv
// sm_trace_fifo: synchronous first-word-fall-through FIFO with flush.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sm_trace_fifo #(
    parameter int WIDTH      = 80,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  push, pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (DEPTH_LOG2+1)'(DEPTH);
    assign pop     = pop_i && !empty_o;
    assign push    = push_i && (!full_o || pop);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + DEPTH_LOG2'(push);
            rd_q  <= rd_q + DEPTH_LOG2'(pop);
            cnt_q <= cnt_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: captures the committed fetch stream with cycle stamps into a FIFO,
// with a cycle limit that halts capture deterministically.
module sm_trace_buffer
    import sm_trace_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int CYCLE_LIMIT = 120,
    parameter int STAMP_W     = TR_STAMP_W
) (
    input logic                clk,
    input logic                rst,
    sm_trace_buffer_if.slave   bus
);
    localparam int ENTRY_W   = tr_entry_w(STAMP_W);
    localparam int INSTR_LSB = tr_instr_lsb(STAMP_W);
    localparam int PC_LSB    = tr_pc_lsb(STAMP_W);
    tr_state_e          state_q;
    logic [STAMP_W-1:0] cnt_q;
    logic               overflow_q, halt_q;
    logic               full, empty, push, drop, hit;
    logic [ENTRY_W-1:0] head;
    assign push = state_q == TR_CAPTURE && bus.commit && !bus.clear;
    // full implies non-empty, so any rdReady frees a slot this cycle
    assign drop = push && full && !bus.rdReady;
    assign hit  = CYCLE_LIMIT != 0 && int'(cnt_q) + 1 == CYCLE_LIMIT;
    sm_trace_fifo #(.WIDTH(ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.clear),
        .push_i  (push),
        .pop_i   (bus.rdReady),
        .data_i  ({bus.pc, bus.instr, cnt_q}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count)
    );
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q    <= TR_IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                TR_IDLE: if (bus.start) state_q <= TR_CAPTURE;
                TR_CAPTURE: begin
                    cnt_q <= &cnt_q ? cnt_q : cnt_q + 1'b1;
                    if (hit) begin
                        state_q <= TR_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.rdValid  = !empty;
    assign bus.rdPc     = head[PC_LSB +: 32];
    assign bus.rdInstr  = head[INSTR_LSB +: 32];
    assign bus.rdStamp  = head[STAMP_W-1:0];
    assign bus.overflow = overflow_q;
    assign bus.halt     = halt_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb_sm_trace_buffer: drives two differently sized trace buffers with identical
// stimulus and compares every output each cycle against a queue-based model.
module tb_sm_trace_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sm_trace_buffer_if #(.DEPTH_LOG2(4), .STAMP_W(16)) ia ();
    sm_trace_buffer_if #(.DEPTH_LOG2(2), .STAMP_W(16)) ib ();
    sm_trace_buffer #(.DEPTH_LOG2(4), .CYCLE_LIMIT(10), .STAMP_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ia));
    sm_trace_buffer #(.DEPTH_LOG2(2), .CYCLE_LIMIT(120), .STAMP_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ib));
    int n_vec = 0;
    int n_err = 0;
    logic [79:0] mq [2][$];
    int mst [2];
    int mcnt [2];
    bit movf [2];
    bit mhalt [2];
    int depth [2] = '{16, 4};
    int lim [2] = '{10, 120};
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_step(input int k, input bit r, input bit s, input bit c, input bit cm,
                              input logic [31:0] p, input logic [31:0] ins, input bit rd);
        bit pop, full;
        pop = mq[k].size() > 0 && rd;
        if (r || c) begin
            mq[k].delete();
            mcnt[k] = 0; movf[k] = 0; mhalt[k] = 0; mst[k] = 0;
        end else begin
            full = mq[k].size() == depth[k];
            if (pop) void'(mq[k].pop_front());
            if (mst[k] == 1 && cm) begin
                if (full && !pop) movf[k] = 1;
                else mq[k].push_back({p, ins, 16'(mcnt[k])});
            end
            if (mst[k] == 0 && s) mst[k] = 1;
            else if (mst[k] == 1) begin
                if (lim[k] != 0 && mcnt[k] + 1 == lim[k]) begin
                    mst[k] = 2; mhalt[k] = 1;
                end
                if (mcnt[k] != 65535) mcnt[k]++;
            end
        end
    endtask
    task automatic check_inst(input int k);
        string t;
        logic [79:0] head;
        t = k ? "B" : "A";
        head = mq[k].size() > 0 ? mq[k][0] : 80'd0;
        check({t, ".rdValid"}, 64'(k ? ib.rdValid : ia.rdValid), 64'(mq[k].size() > 0));
        check({t, ".rdPc"}, 64'(k ? ib.rdPc : ia.rdPc), 64'(head[79:48]));
        check({t, ".rdInstr"}, 64'(k ? ib.rdInstr : ia.rdInstr), 64'(head[47:16]));
        check({t, ".rdStamp"}, 64'(k ? ib.rdStamp : ia.rdStamp), 64'(head[15:0]));
        check({t, ".count"}, k ? 64'(ib.count) : 64'(ia.count), 64'(mq[k].size()));
        check({t, ".overflow"}, 64'(k ? ib.overflow : ia.overflow), 64'(movf[k]));
        check({t, ".halt"}, 64'(k ? ib.halt : ia.halt), 64'(mhalt[k]));
        check({t, ".state"}, 64'(k ? ib.state : ia.state), 64'(mst[k]));
    endtask
    task automatic tick(input bit r, input bit s, input bit c, input bit cm,
                        input logic [31:0] p, input logic [31:0] ins, input bit rd);
        rst = r;
        ia.start = s; ia.clear = c; ia.commit = cm; ia.pc = p; ia.instr = ins; ia.rdReady = rd;
        ib.start = s; ib.clear = c; ib.commit = cm; ib.pc = p; ib.instr = ins; ib.rdReady = rd;
        for (int k = 0; k < 2; k++) model_step(k, r, s, c, cm, p, ins, rd);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_inst(k);
    endtask
    initial begin
        tick(1, 0, 0, 0, 0, 0, 0);
        check("reset.stateA", 64'(ia.state), 64'd0);
        check("reset.validB", 64'(ib.rdValid), 64'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        // three commits, then drain
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 32'(i * 4), 32'h24020005, 0);
        check("basic.head_stamp", 64'(ia.rdStamp), 64'd0);
        check("basic.countA", 64'(ia.count), 64'd3);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 1);
        check("basic.drained", 64'(ia.count), 64'd0);
        // continuous commit into the cycle limit
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) tick(0, 0, 0, 1, 32'h100 + 32'(i * 4), $urandom, 0);
        check("limit.halt", 64'(ia.halt), 64'd1);
        check("limit.state", 64'(ia.state), 64'd2);
        check("limit.count", 64'(ia.count), 64'd10);
        check("limit.ovfB", 64'(ib.overflow), 64'd1);
        // reset during HALTED with entries present
        tick(1, 0, 0, 0, 0, 0, 0);
        check("rst.halt", 64'(ia.halt), 64'd0);
        check("rst.count", 64'(ia.count), 64'd0);
        // fill B to full, then push+pop together
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 32'h200 + 32'(i * 4), $urandom, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 32'h300 + 32'(i * 4), $urandom, 1);
        check("fullpp.count", 64'(ib.count), 64'd4);
        check("fullpp.ovf", 64'(ib.overflow), 64'd0);
        tick(0, 0, 0, 1, 32'h400, $urandom, 0);
        check("full.ovf", 64'(ib.overflow), 64'd1);
        // clear with start in the same cycle while entries are queued
        tick(0, 1, 1, 0, 0, 0, 0);
        check("clear.state", 64'(ia.state), 64'd0);
        check("clear.valid", 64'(ia.rdValid), 64'd0);
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h500, 32'h1, 0);
        check("clear.stamp0", 64'(ia.rdStamp), 64'd0);
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 1) == 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sm_trace_buffer.md
Name: sm_trace_buffer

Overview:
- Debug capture stage directly downstream of the CPU core.
- Consumes the per-cycle fetch stream (PC plus instruction word) and records up to 2^DEPTH_LOG2 entries, each tagged with a cycle stamp, in a FIFO.
- A host, UART bridge or bench reads the entries out through a valid/ready port.
- Provides a hardware cycle limit that raises halt, so on-board runs stop deterministically in the same way the simulation timeout does.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- CYCLE_LIMIT, 120, cycle count at which capture stops and halt asserts; 0 disables the limit.
- STAMP_W, 16, width of the cycle stamp.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE->CAPTURE.
- clear  in  1  one-cycle pulse; flush FIFO, zero counters, go to IDLE.
- commit  in  1  CPU presents a valid pc/instr this cycle.
- pc  in  32  PC of the current instruction.
- instr  in  32  current instruction word.
- rdReady  in  1  consumer accepts the head entry.
- rdValid  out  1  FIFO non-empty.
- rdPc  out  32  head entry PC.
- rdInstr  out  32  head entry instruction.
- rdStamp  out  STAMP_W  head entry cycle stamp.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky; an entry was dropped.
- halt  out  1  cycle limit reached.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, FIFO empty, count=0, rdValid=0, overflow=0, halt=0, cycle counter=0. rdPc, rdInstr and rdStamp read 0 while empty.
- FSM encoding: IDLE=0, CAPTURE=1, HALTED=2.
  - IDLE: start -> CAPTURE.
  - CAPTURE: the cycle counter increments every clk (saturates at all-ones). When counter+1 == CYCLE_LIMIT (CYCLE_LIMIT != 0), go to HALTED and register halt=1.
  - HALTED: no captures. halt stays 1 until clear or rst.
  - clear in any state -> IDLE, FIFO flushed, counter=0, overflow=0, halt=0.
  - clear has priority over start in the same cycle.
  - start while in CAPTURE or HALTED is ignored.
- Capture: in CAPTURE, commit=1 pushes {pc, instr, counter} (the counter value before increment).
  - The first captured entry after start has stamp 0.
  - A push in the cycle that enters HALTED is still accepted.
- Read: the head entry is shown combinationally from the FIFO (first-word-fall-through). A pop occurs when rdValid && rdReady. Reads are allowed in every state, including HALTED and IDLE after capture.
- Full: a push while count == depth and no pop in the same cycle is dropped and sets overflow. Existing entries are kept; no overwrite of the oldest.
- Simultaneous push and pop while full: both succeed, count unchanged, no overflow.
- Simultaneous push and pop while empty: the pop is ignored (rdValid=0); the push lands and rdValid=1 next cycle.
- Pointers: DEPTH_LOG2-bit read and write pointers wrap modulo depth. count is updated +1, -1 or 0 per cycle.
- Latency: an entry pushed at edge N is visible on rdValid/rdPc after edge N. rdReady with no entry present has no effect.
- Reset mid-operation: an identical result to power-up reset. Any partially read entry is lost.

Decomposition:
- Package sm_trace_pkg: state encodings (TR_IDLE, TR_CAPTURE, TR_HALTED), entry width constant (64+STAMP_W), and the entry field offsets.
- Sub-module sm_trace_fifo: generic synchronous FWFT FIFO with parameters WIDTH and DEPTH_LOG2, providing push/pop/full/empty/count.
- The top level holds the FSM, cycle counter, overflow/halt flags and entry packing.

Test Plan:
- Reset, then start, then commit each cycle with pc=0x00, 0x04, 0x08 and instr=0x24020005, drain with rdReady=1 -> three entries read back with stamps 0, 1, 2 and matching pc/instr; count returns to 0.
- CYCLE_LIMIT=10, start, commit continuously, rdReady=0 -> halt=1 after the 10th capture cycle, state=2, exactly 10 entries held, no further pushes.
- DEPTH_LOG2=2, 6 commits with rdReady=0 -> count=4, overflow=1, the entries read back are the first four pushed.
- Full FIFO, commit=1 and rdReady=1 held for 3 cycles -> count stays 4, overflow stays 0, the popped entries are in order.
- Mid-capture with 3 entries queued: clear (and start in the same cycle) -> state=IDLE, count=0, rdValid=0, halt=0; a later start gives a first stamp of 0.
- rst asserted for one cycle during HALTED with entries present -> all outputs return to reset values on the next edge.
